l1_ring_controller: RTL
=======================

Name: l1_ring_controller

Overview:
- Per-core ring node that sits directly downstream of the L1 miss queue and drives the core's slot on the cache-coherence ring.
- Takes pending miss requests from the miss queue and injects them into empty ring slots.
- Snoops every passing packet against the miss queue. When a response for this core arrives, it fills the data cache and issues the thread wakeup. It also forwards foreign write-invalidates to the data cache.
- Fixed 2-cycle pass-through latency, packet_in to packet_out.

Parameters:
- CORE_ID, 0, ring node id of this core; compared against packet dest_core.
- NUM_ENTRIES, `THREADS_PER_CORE, number of miss-queue entries (one per thread).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low (0 = in reset)
- packet_in  in  ring_packet_t  packet from the previous ring node
- packet_out  out  ring_packet_t  registered packet to the next ring node
- snoop_en  out  1  lookup request to the miss queue
- snoop_addr  out  32  line address being looked up
- snoop_hit  in  1  lookup result, valid one cycle after snoop_en
- snoop_hit_entry  in  NUM_ENTRIES  matching entry (binary index, sized as in the miss queue)
- snoop_state  in  pending_miss_state_t  state of the hit entry
- wake_en  out  1  wake the threads waiting on wake_entry
- wake_entry  out  NUM_ENTRIES  entry being completed
- request_ready  in  1  miss queue has an unsent request
- request_address  in  32  line address of that request
- request_store  in  1  1 = write-invalidate, 0 = read-shared
- request_ack  out  1  request consumed this cycle
- dcache_update_en  out  1  write a filled line into the data cache
- dcache_update_addr  out  32  address of the filled line
- dcache_update_data  out  `CACHE_LINE_BITS  line data
- dcache_invalidate_en  out  1  invalidate a line (foreign write)
- dcache_invalidate_addr  out  32  address to invalidate

Behaviour:
- Reset, and any time reset is low mid-operation: s1.valid, packet_out.valid, wake_en, dcache_update_en and dcache_invalidate_en are 0. request_ack is held 0. In-flight packets are dropped.
- Cycle 0: snoop_en = packet_in.valid and snoop_addr = packet_in.address, both combinational. s1 <= packet_in.
- Cycle 1: snoop_hit, snoop_hit_entry and snoop_state are aligned with s1.
- Response match (ours) = s1.valid && s1.ack && s1.dest_core == CORE_ID && snoop_hit && state agreement:
  - PKT_READ_SHARED requires PM_READ_SENT.
  - PKT_WRITE_INVALIDATE requires PM_WRITE_SENT.
  - Any other combination: the packet is forwarded unchanged and no wake is issued.
- When ours is true, registered at cycle 2:
  - wake_en = 1, wake_entry = snoop_hit_entry.
  - dcache_update_en = 1, with addr/data taken from s1.
  - The slot is consumed and becomes free.
- Foreign invalidate = s1.valid && s1.ack && type == PKT_WRITE_INVALIDATE && dest_core != CORE_ID. Registered at cycle 2 as dcache_invalidate_en/addr. The packet is still forwarded.
- Slot free = !s1.valid || ours.
- Injection, cycle 1: when the slot is free and request_ready is high:
  - request_ack = 1, combinational, for one cycle.
  - packet_out <= {valid=1, ack=0, dest_core=CORE_ID, type = request_store ? PKT_WRITE_INVALIDATE : PKT_READ_SHARED, address = request_address, data = 0}.
- Otherwise, packet_out <= s1 if not consumed, or an invalid packet if consumed.
- A response and an injection may occur in the same cycle, with the slot reused immediately.
- At most one wake, one injection and one dcache write per cycle.
- request_ack is never asserted while request_ready is low.
- Unacked packets addressed to this core (no responder) are forwarded unchanged; retry is out of scope.
- Snoop misses on ack'd packets for this core (stale response) are forwarded and not woken. Assert on this condition in simulation.

Decomposition:
- Shared package defines.v holds:
  - ring_packet_t: valid, ack, type, dest_core[`CORE_ID_WIDTH], address scalar_t, data[`CACHE_LINE_BITS].
  - ring_packet_type_t enum: PKT_READ_SHARED, PKT_WRITE_INVALIDATE.
  - The existing pending_miss_state_t, plus `CORE_ID_WIDTH and `CACHE_LINE_BITS (512).
- No sub-module; a single file with a two-register pipeline and the response/inject decode.

Test Plan:
- Idle ring, request_ready=1, addr 0x1000, store=0 → request_ack pulses exactly once in cycle 1; packet_out valid at cycle 2 with type READ_SHARED, dest=CORE_ID, ack=0.
- Ring slot occupied every cycle by a foreign packet, request_ready=1 → request_ack stays 0 and packets pass unchanged with 2-cycle latency; injection occurs on the first empty slot.
- Response ack=1, dest=CORE_ID, addr 0x2040, snoop_hit=1, entry 2, state READ_SENT → at cycle 2 wake_en=1, wake_entry=2, dcache_update_addr=0x2040 with matching data; packet_out.valid=0, or a new request if request_ready=1 in the same cycle.
- Same response but snoop_state=READ_PENDING, or snoop_hit=0 → no wake, no dcache update, packet forwarded intact.
- Foreign WRITE_INVALIDATE, ack=1, dest=CORE_ID+1, addr 0x3000 → dcache_invalidate_en=1 with addr 0x3000 at cycle 2; packet forwarded.
- Drive reset low mid-stream with valid packets in s1/packet_out → outputs go to 0 asynchronously; after release, the first output is an invalid packet.

Source files
------------

// File: rtl/l1_ring_controller_pkg.sv
// Shared types for the L1 ring node: ring packet layout, packet types,
// miss-queue entry states and the core/line sizing constants.
package l1_ring_controller_pkg;

  localparam int CORE_ID_WIDTH    = 4;
  localparam int CACHE_LINE_BITS  = 512;
  localparam int THREADS_PER_CORE = 4;

  typedef logic [31:0] scalar_t;

  typedef enum logic {
    PKT_READ_SHARED      = 1'b0,
    PKT_WRITE_INVALIDATE = 1'b1
  } ring_packet_type_t;

  typedef enum logic [2:0] {
    PM_INVALID       = 3'd0,
    PM_READ_PENDING  = 3'd1,
    PM_WRITE_PENDING = 3'd2,
    PM_READ_SENT     = 3'd3,
    PM_WRITE_SENT    = 3'd4
  } pending_miss_state_t;

  typedef struct packed {
    logic                       valid;
    logic                       ack;
    ring_packet_type_t          packet_type;
    logic [CORE_ID_WIDTH-1:0]   dest_core;
    scalar_t                    address;
    logic [CACHE_LINE_BITS-1:0] data;
  } ring_packet_t;

  // A response only completes a miss whose request of the same kind is
  // already out on the ring; anything else is left for the owner to sort out.
  function automatic logic state_agrees(input ring_packet_type_t pkt_type,
                                        input pending_miss_state_t state);
    logic agree;
    case (pkt_type)
      PKT_READ_SHARED:      agree = (state == PM_READ_SENT);
      PKT_WRITE_INVALIDATE: agree = (state == PM_WRITE_SENT);
      default:              agree = 1'b0;
    endcase
    return agree;
  endfunction

endpackage

// File: rtl/l1_ring_controller_checker.sv
// Simulation-side checker for the L1 ring node: flags acknowledged
// responses addressed to this core that the miss queue no longer knows
// about (stale responses). The node itself just forwards such packets.
module l1_ring_controller_checker
  import l1_ring_controller_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_ack,
  input  logic [CORE_ID_WIDTH-1:0] in_dest_core,
  input  logic                     snoop_hit
);

  localparam logic [CORE_ID_WIDTH-1:0] CORE_ID_L = CORE_ID[CORE_ID_WIDTH-1:0];

  logic                     s1_valid_r;
  logic                     s1_ack_r;
  logic [CORE_ID_WIDTH-1:0] s1_dest_r;

  // Track the stage-1 packet header so the snoop result can be judged against it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_ack_r   <= 1'b0;
      s1_dest_r  <= '0;
    end else begin
      s1_valid_r <= in_valid;
      s1_ack_r   <= in_ack;
      s1_dest_r  <= in_dest_core;
    end
  end

  stale_response_a: assert property (
    @(posedge clk) disable iff (!reset)
    (s1_valid_r && s1_ack_r && (s1_dest_r == CORE_ID_L)) |-> snoop_hit
  ) else $error("l1_ring_controller: stale response for core %0d (snoop miss)", CORE_ID);

endmodule

// File: rtl/l1_ring_controller.sv
// l1_ring_controller: per-core node on the coherence ring. Snoops passing
// packets against the miss queue, completes our own responses (cache fill
// plus thread wakeup), forwards foreign write-invalidates to the data cache
// and injects pending miss requests into free slots. Packets take exactly
// two cycles from packet_in to packet_out.
module l1_ring_controller
  import l1_ring_controller_pkg::*;
#(
  parameter  int CORE_ID         = 0,
  parameter  int NUM_ENTRIES     = THREADS_PER_CORE,
  localparam int ENTRY_IDX_WIDTH = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  ring_packet_t               packet_in,
  output ring_packet_t               packet_out,
  output logic                       snoop_en,
  output logic [31:0]                snoop_addr,
  input  logic                       snoop_hit,
  input  logic [ENTRY_IDX_WIDTH-1:0] snoop_hit_entry,
  input  pending_miss_state_t        snoop_state,
  output logic                       wake_en,
  output logic [ENTRY_IDX_WIDTH-1:0] wake_entry,
  input  logic                       request_ready,
  input  logic [31:0]                request_address,
  input  logic                       request_store,
  output logic                       request_ack,
  output logic                       dcache_update_en,
  output logic [31:0]                dcache_update_addr,
  output logic [CACHE_LINE_BITS-1:0] dcache_update_data,
  output logic                       dcache_invalidate_en,
  output logic [31:0]                dcache_invalidate_addr
);

  localparam logic [CORE_ID_WIDTH-1:0] CORE_ID_L = CORE_ID[CORE_ID_WIDTH-1:0];

  // Stage-1 packet (aligned with the miss-queue snoop result) and the
  // registered outputs of stage 2.
  ring_packet_t                 s1_r;
  ring_packet_t                 packet_out_r;
  logic                         wake_en_r;
  logic [ENTRY_IDX_WIDTH-1:0]   wake_entry_r;
  logic                         dcache_update_en_r;
  logic [31:0]                  dcache_update_addr_r;
  logic [CACHE_LINE_BITS-1:0]   dcache_update_data_r;
  logic                         dcache_invalidate_en_r;
  logic [31:0]                  dcache_invalidate_addr_r;

  logic                         for_us_ack_s;
  logic                         ours_s;
  logic                         foreign_inv_s;
  logic                         slot_free_s;
  logic                         inject_s;
  ring_packet_t                 next_packet_s;

  // The miss-queue lookup is issued straight from the incoming packet
  assign snoop_en   = packet_in.valid;
  assign snoop_addr = packet_in.address;

  // Stage-1 register; in-flight packets are dropped while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_r <= '0;
    end else begin
      s1_r <= packet_in;
    end
  end

  // Classify the stage-1 packet and decide whether the slot can take a request
  always_comb begin
    for_us_ack_s  = s1_r.valid && s1_r.ack && (s1_r.dest_core == CORE_ID_L);
    ours_s        = for_us_ack_s && snoop_hit
                    && state_agrees(s1_r.packet_type, snoop_state);
    foreign_inv_s = s1_r.valid && s1_r.ack
                    && (s1_r.packet_type == PKT_WRITE_INVALIDATE)
                    && (s1_r.dest_core != CORE_ID_L);
    slot_free_s   = !s1_r.valid || ours_s;
    // Never acknowledge without a request, and never while in reset
    inject_s      = reset && slot_free_s && request_ready;
  end

  assign request_ack = inject_s;

  // Pick what leaves on the ring: a new request, an empty slot, or the packet as it came
  always_comb begin
    next_packet_s = '0;
    if (inject_s) begin
      next_packet_s.valid       = 1'b1;
      next_packet_s.ack         = 1'b0;
      next_packet_s.dest_core   = CORE_ID_L;
      next_packet_s.packet_type = request_store ? PKT_WRITE_INVALIDATE : PKT_READ_SHARED;
      next_packet_s.address     = request_address;
      next_packet_s.data        = '0;
    end else if (slot_free_s) begin
      next_packet_s = '0;
    end else begin
      next_packet_s = s1_r;
    end
  end

  // Stage-2 ring output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      packet_out_r <= '0;
    end else begin
      packet_out_r <= next_packet_s;
    end
  end

  // Completion of our own miss: wake the waiting threads and fill the line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wake_en_r            <= 1'b0;
      wake_entry_r         <= '0;
      dcache_update_en_r   <= 1'b0;
      dcache_update_addr_r <= 32'h0000_0000;
      dcache_update_data_r <= '0;
    end else begin
      wake_en_r          <= ours_s;
      dcache_update_en_r <= ours_s;
      if (ours_s) begin
        wake_entry_r         <= snoop_hit_entry;
        dcache_update_addr_r <= s1_r.address;
        dcache_update_data_r <= s1_r.data;
      end
    end
  end

  // Another core's write was granted: drop our copy of that line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcache_invalidate_en_r   <= 1'b0;
      dcache_invalidate_addr_r <= 32'h0000_0000;
    end else begin
      dcache_invalidate_en_r <= foreign_inv_s;
      if (foreign_inv_s) begin
        dcache_invalidate_addr_r <= s1_r.address;
      end
    end
  end

  assign packet_out             = packet_out_r;
  assign wake_en                = wake_en_r;
  assign wake_entry             = wake_entry_r;
  assign dcache_update_en       = dcache_update_en_r;
  assign dcache_update_addr     = dcache_update_addr_r;
  assign dcache_update_data     = dcache_update_data_r;
  assign dcache_invalidate_en   = dcache_invalidate_en_r;
  assign dcache_invalidate_addr = dcache_invalidate_addr_r;

endmodule
